// File: rtl/clock_hms_core.sv
// Hours/minutes/seconds timekeeping core with 1 Hz tick-enable, debounced set buttons and 12/24-hour display.
// Optional alarm comparator is built when CLOCK_HMS_ALARM_EN is defined.
module clock_hms_core #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic       clk_100MHz,
  input  logic       resetn,
  input  logic       hour_in,
  input  logic       min_in,
  input  logic       sec_in,
  input  logic       start_stop,
  input  logic       mode_in,
`ifdef CLOCK_HMS_ALARM_EN
  input  logic [4:0] alarm_hour_in,
  input  logic [5:0] alarm_min_in,
  input  logic       alarm_en_in,
  output logic       alarm_out,
`endif
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       pm_out,
  output logic       tick_out
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RPT_MAX   = RW'(REPEAT_CYCLES - 1);

  // Button index: 2 = hour, 1 = minute, 0 = second.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2, level, level_d, set_ev;
  logic [DW-1:0] db_cnt  [3];
  logic [RW-1:0] rpt_cnt [3];

  logic [PW-1:0] presc, presc_n;
  logic          tick, tick_req, tick_pend, any_set, apply_tick;
  logic [4:0]    hr, hr_n;
  logic [5:0]    mn, mn_n, sc, sc_n;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  assign btn_raw = {hour_in, min_in, sec_in};

  always_ff @(posedge clk_100MHz) begin
    if (!resetn) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i]  <= '0;
        rpt_cnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
        // Counter restarts on every event so repeats land exactly REPEAT_CYCLES apart.
        rpt_cnt[i] <= (!level[i] || set_ev[i]) ? '0 : rpt_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    set_ev = '0;
    for (int i = 0; i < 3; i++)
      set_ev[i] = level[i] & (~level_d[i] | (rpt_cnt[i] == RPT_MAX));
  end

  // A tick colliding with a set event waits in tick_pend for the first set-free cycle.
  always_comb begin
    tick       = start_stop && (presc == PRESC_MAX);
    tick_req   = tick | tick_pend;
    any_set    = |set_ev;
    apply_tick = tick_req & ~any_set;
    presc_n    = (!start_stop || set_ev[0] || tick) ? '0 : presc + 1'b1;
    hr_n = hr;
    mn_n = mn;
    sc_n = sc;
    if (apply_tick) begin
      sc_n = inc60(sc);
      if (sc == 6'd59) mn_n = inc60(mn);
      if (sc == 6'd59 && mn == 6'd59) hr_n = inc24(hr);
    end else begin
      if (set_ev[2]) hr_n = inc24(hr);
      if (set_ev[1]) mn_n = inc60(mn);
      if (set_ev[0]) sc_n = inc60(sc);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!resetn) begin
      presc     <= '0;
      tick_pend <= 1'b0;
      hr        <= '0;
      mn        <= '0;
      sc        <= '0;
    end else begin
      presc     <= presc_n;
      tick_pend <= tick_req & any_set;
      hr        <= hr_n;
      mn        <= mn_n;
      sc        <= sc_n;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!resetn) begin
      hour_out <= mode_in ? 5'd0 : 5'd12;
      min_out  <= '0;
      sec_out  <= '0;
      pm_out   <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      min_out  <= mn;
      sec_out  <= sc;
      tick_out <= apply_tick;
      if (mode_in) begin
        hour_out <= hr;
        pm_out   <= 1'b0;
      end else begin
        hour_out <= (hr == 5'd0 || hr == 5'd12) ? 5'd12 :
                    (hr > 5'd12) ? hr - 5'd12 : hr;
        pm_out   <= (hr >= 5'd12);
      end
    end
  end

`ifdef CLOCK_HMS_ALARM_EN
  always_ff @(posedge clk_100MHz) begin
    if (!resetn) alarm_out <= 1'b0;
    else         alarm_out <= alarm_en_in && (hr == alarm_hour_in) && (mn == alarm_min_in);
  end
`else
  // This build carries no alarm comparator.
`endif

endmodule

// File: tb/tb_clock_hms_core.sv
// Self-checking bench for clock_hms_core: vector table, hand sequences for corner cases,
// and a randomized run checked against a seconds-of-day reference model.
module tb_clock_hms_core;

  localparam int CLK_HZ        = 10;
  localparam int DB_CYCLES     = 4;
  localparam int REPEAT_CYCLES = 20;

  logic       clk, resetn, hour_in, min_in, sec_in, start_stop, mode_in;
  logic [4:0] hour_out;
  logic [5:0] min_out, sec_out;
  logic       pm_out, tick_out;
`ifdef CLOCK_HMS_ALARM_EN
  logic [4:0] alarm_hour_in;
  logic [5:0] alarm_min_in;
  logic       alarm_en_in, alarm_out;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int holdH; int holdM; int holdS; int mode;
    int expHour; int expMin; int expSec; int expPm;
  } vec_t;
  vec_t vecs [7];

  clock_hms_core #(
    .CLK_HZ(CLK_HZ), .DB_CYCLES(DB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk_100MHz(clk), .resetn(resetn),
    .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .start_stop(start_stop), .mode_in(mode_in),
`ifdef CLOCK_HMS_ALARM_EN
    .alarm_hour_in(alarm_hour_in), .alarm_min_in(alarm_min_in),
    .alarm_en_in(alarm_en_in), .alarm_out(alarm_out),
`endif
    .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out),
    .pm_out(pm_out), .tick_out(tick_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s, input int pm);
    checkOutput({tag, " hour"}, int'(hour_out), h);
    checkOutput({tag, " min"}, int'(min_out), m);
    checkOutput({tag, " sec"}, int'(sec_out), s);
    checkOutput({tag, " pm"}, int'(pm_out), pm);
  endtask

  // Holds each button high for its given number of cycles (0 = untouched), then lets debounce settle.
  task automatic pressButtons(input int holdH, input int holdM, input int holdS);
    int longest;
    longest = holdH;
    if (holdM > longest) longest = holdM;
    if (holdS > longest) longest = holdS;
    hour_in = (holdH > 0);
    min_in  = (holdM > 0);
    sec_in  = (holdS > 0);
    for (int c = 1; c <= longest; c++) begin
      @(negedge clk);
      if (c == holdH) hour_in = 1'b0;
      if (c == holdM) min_in  = 1'b0;
      if (c == holdS) sec_in  = 1'b0;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    mode_in = (v.mode != 0);
    pressButtons(v.holdH, v.holdM, v.holdS);
    checkTime($sformatf("vec%0d", idx), v.expHour, v.expMin, v.expSec, v.expPm);
  endtask

  function automatic int dispHour(input int h, input int md);
    if (md != 0) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  initial begin
    int secs, streak, expH, expM, expS, expPm, expTick;
    bit ss, md, tk;

    // Holds are cycle counts; a hold of H gives ceil(H/REPEAT_CYCLES) increments.
    vecs[0] = '{250,    0,    0, 0,  1,  0,  0, 1};
    vecs[1] = '{  0,    0,    0, 1, 13,  0,  0, 0};
    vecs[2] = '{210,    0,    0, 0, 12,  0,  0, 0};
    vecs[3] = '{240,    0,    0, 0, 12,  0,  0, 1};
    vecs[4] = '{ 20,   60,   80, 0,  1,  3,  4, 1};
    vecs[5] = '{  0, 1140, 1120, 1, 13,  0,  0, 0};
    vecs[6] = '{200, 1180, 1160, 0, 11, 59, 58, 1};

    resetn = 1'b0; hour_in = 1'b0; min_in = 1'b0; sec_in = 1'b0;
    start_stop = 1'b0; mode_in = 1'b0;
`ifdef CLOCK_HMS_ALARM_EN
    alarm_hour_in = 5'd7; alarm_min_in = 6'd30; alarm_en_in = 1'b1;
`endif
    repeat (3) @(negedge clk);
    checkTime("reset", 12, 0, 0, 0);
    checkOutput("reset tick", int'(tick_out), 0);
`ifdef CLOCK_HMS_ALARM_EN
    checkOutput("reset alarm", int'(alarm_out), 0);
`endif
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("post-reset hour 12h", int'(hour_out), 12);
    mode_in = 1'b1;
    @(negedge clk);
    checkOutput("mode 24h hour", int'(hour_out), 0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Run through midnight from 23:59:58.
    mode_in = 1'b1;
    @(negedge clk);
    start_stop = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      checkOutput($sformatf("run tick c%0d", c), int'(tick_out), (c % 10 == 0) ? 1 : 0);
      if (c == 11) checkTime("run 23:59:59", 23, 59, 59, 0);
      if (c == 21) checkTime("run 00:00:00", 0, 0, 0, 0);
    end
    start_stop = 1'b0;
    repeat (2) @(negedge clk);

    // Bounced hour press, then a long hold with auto-repeat.
    hour_in = 1'b1; @(negedge clk);
    hour_in = 1'b0; @(negedge clk);
    hour_in = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 7)  checkOutput("bounce before debounce", int'(hour_out), 0);
      if (c == 15) checkOutput("bounce first incr", int'(hour_out), 1);
      if (c == 35) checkOutput("bounce repeat 1", int'(hour_out), 2);
      if (c == 55) checkOutput("bounce repeat 2", int'(hour_out), 3);
    end
    hour_in = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("bounce after release", int'(hour_out), 3);

    // Set 00:00:05, then a sec press landing on the terminal-count cycle.
    pressButtons(420, 0, 100);
    checkTime("pre-collision", 0, 0, 5, 0);
    start_stop = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 3)  sec_in = 1'b1;
      if (c == 13) sec_in = 1'b0;
      if (c == 10) begin
        checkOutput("collision tick deferred", int'(tick_out), 0);
        checkOutput("collision sec before", int'(sec_out), 5);
      end
      if (c == 11) begin
        checkOutput("pending tick applied", int'(tick_out), 1);
        checkOutput("collision sec set", int'(sec_out), 6);
      end
      if (c == 12) begin
        checkOutput("collision sec tick", int'(sec_out), 7);
        checkOutput("collision min", int'(min_out), 0);
      end
      if (c == 19) checkOutput("collision next tick early", int'(tick_out), 0);
      if (c == 20) checkOutput("collision next tick", int'(tick_out), 1);
      if (c == 21) checkOutput("collision sec after", int'(sec_out), 8);
    end
    start_stop = 1'b0;
    repeat (12) @(negedge clk);

    // A sec press mid-count restarts the prescaler.
    sec_in = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      if (e == 2)  start_stop = 1'b1;
      if (e == 10) sec_in = 1'b0;
      if (e == 8)  checkOutput("clear sec set", int'(sec_out), 9);
      if (e == 12) checkOutput("clear old tick slot", int'(tick_out), 0);
      if (e == 17) checkOutput("clear new tick slot", int'(tick_out), 1);
      if (e == 18) checkOutput("clear sec tick", int'(sec_out), 10);
    end
    start_stop = 1'b0;
    repeat (12) @(negedge clk);

`ifdef CLOCK_HMS_ALARM_EN
    pressButtons(140, 580, 980);
    checkTime("alarm preset", 7, 29, 59, 0);
    checkOutput("alarm before", int'(alarm_out), 0);
    start_stop = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 10) checkOutput("alarm at tick", int'(alarm_out), 0);
      if (c == 11) checkOutput("alarm raised", int'(alarm_out), 1);
    end
    start_stop = 1'b0;
    @(negedge clk);
    checkOutput("alarm held", int'(alarm_out), 1);
    alarm_en_in = 1'b0;
    @(negedge clk);
    checkOutput("alarm disabled", int'(alarm_out), 0);
`endif

    // Reset while running.
    mode_in = 1'b0; start_stop = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkTime("midreset", 12, 0, 0, 0);
    checkOutput("midreset tick", int'(tick_out), 0);
    repeat (3) @(negedge clk);
    checkOutput("midreset held sec", int'(sec_out), 0);

    // Randomized run against a seconds-of-day model.
    secs = 0; streak = 0; md = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ss = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 31) == 0) md = ~md;
      start_stop = ss; mode_in = md;
      if (ss) begin
        streak++;
        tk = (streak % CLK_HZ == 0);
      end else begin
        streak = 0;
        tk = 1'b0;
      end
      expH    = dispHour(secs / 3600, int'(md));
      expM    = (secs / 60) % 60;
      expS    = secs % 60;
      expPm   = (md == 1'b0 && secs / 3600 >= 12) ? 1 : 0;
      expTick = int'(tk);
      secs    = (secs + int'(tk)) % 86400;
      @(negedge clk);
      checkTime($sformatf("rand%0d", i), expH, expM, expS, expPm);
      checkOutput($sformatf("rand%0d tick", i), int'(tick_out), expTick);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_hms_core.md
# clock_hms_core

Parametrised hours/minutes/seconds timekeeping core for the board clock designs. It runs directly on the board clock with an internal 1 Hz tick-enable, so the design needs no derived clocks. It debounces the three set buttons with auto-repeat and selects 12-hour or 24-hour display at run time. It replaces the fixed 12-hour top level and feeds the display/BCD stage.

## Interface
- CLK_HZ, 100_000_000: input clock cycles per second; the tick prescaler terminal count is CLK_HZ-1.
- DB_CYCLES, 1_000_000: consecutive stable samples required for a debounced level change (10 ms at 100 MHz).
- REPEAT_CYCLES, 25_000_000: auto-repeat period while a set button is held.
- clk_100MHz  in  1  system clock; single clock domain.
- resetn  in  1  reset; synchronous, active-low.
- hour_in, min_in, sec_in  in  1  raw, asynchronous set buttons; active-high.
- start_stop  in  1  level input: 1 = running, 0 = stopped. Buttons work in both states.
- mode_in  in  1  level input: 0 = 12-hour display, 1 = 24-hour display.
- hour_out  out  5  displayed hour: 1..12 in 12-hour mode, 0..23 in 24-hour mode.
- min_out, sec_out  out  6  displayed minute and second, 0..59.
- pm_out  out  1  PM indicator. Only valid in 12-hour mode; forced to 0 in 24-hour mode.
- tick_out  out  1  one-cycle pulse on each applied 1 Hz tick.
- alarm_hour_in  in  5, alarm_min_in  in  6, alarm_en_in  in  1, alarm_out  out  1: present only with ALARM_EN (see Configuration).

## Operation
- Time is held internally in 24-hour format: hr 0..23, mn 0..59, sc 0..59.
- Output mapping (registered):
  - 12-hour mode: hour_out = 12 when hr is 0 or 12, otherwise hr mod 12; pm_out = (hr >= 12).
  - 24-hour mode: hour_out = hr; pm_out = 0.
- Prescaler:
  - Counts 0..CLK_HZ-1 while start_stop=1 and raises a tick at the terminal count.
  - Held at 0 while start_stop=0.
- Tick: sc increments, with carry into mn and then hr. 23:59:59 wraps to 00:00:00.
- Debounce, per button:
  - 2-FF synchroniser, then a stability counter.
  - The debounced level flips only after DB_CYCLES consecutive samples that differ from the current level.
- Set events:
  - The debounced rising edge produces one increment event.
  - While the debounced level stays high, a further event occurs every REPEAT_CYCLES.
  - Release stops repeats and clears the repeat counter.
- Set increments:
  - Field-local and with no carry: sc 59->0, mn 59->0, hr 23->0.
  - An sc increment also clears the prescaler to 0.
  - Simultaneous events on several buttons each apply in the same cycle.
- Tick/set collision: if a tick and any set event occur in the same cycle, the set event is applied and the tick is latched in a pending flag. The pending tick is applied on the next cycle that has no set event. No tick is ever lost.
- mode_in changes only the output mapping and never alters the stored time.

## Timing
- Reset values:
  - Internal time is 00:00:00. hour_out = 12 in 12-hour mode, 0 in 24-hour mode.
  - min_out=0, sec_out=0, pm_out=0, tick_out=0, alarm_out=0.
  - Prescaler, debounce and repeat counters are 0; debounced levels are 0; pending tick is cleared.
- Reset mid-operation: all of the above values apply on the first clock edge with resetn=0 and are held while resetn is low.
- Set latency: a raw button rising edge, held stable, produces a state update 2+DB_CYCLES+1 cycles later. The outputs reflect it one cycle after that.
- Tick latency:
  - The tick updates state on the terminal-count cycle; tick_out is asserted in that same cycle's output register update.
  - Outputs reflect the new time one cycle after the state update.
- mode_in to outputs: 1 cycle.
- Tick period: exactly CLK_HZ cycles while running with no collisions; a collision defers the tick by 1 cycle.

## Configuration
- Macro: CLOCK_HMS_ALARM_EN.
- Defined:
  - Alarm ports exist.
  - alarm_out is registered and equals alarm_en_in AND (hr == alarm_hour_in, 24-hour encoding) AND (mn == alarm_min_in).
  - alarm_out stays high for the matching minute and drops 1 cycle after alarm_en_in falls.
- Undefined: alarm ports and alarm logic are absent; all other behaviour is identical.

## Test plan
Bench parameters: CLK_HZ=10, DB_CYCLES=4, REPEAT_CYCLES=20.
- Reset, mode_in=0 -> hour_out=12, min_out=0, sec_out=0, pm_out=0. Switch mode_in=1 -> hour_out=0 one cycle later.
- Set time to 23:59:58, start_stop=1, run 20 cycles -> shows 23:59:59, then 00:00:00. tick_out pulses every 10 cycles.
- hour_in bounce (1,0,1 on alternate cycles), then stable high for 60 cycles -> exactly one increment at debounce, then repeats at 20-cycle spacing (3 increments total). Release -> no further change.
- Force a sec_in event on the prescaler terminal-count cycle at 00:00:05 -> sec increments to 6, prescaler cleared, pending tick applied the next cycle -> sec 7. Minute unchanged.
- hr=13, mode_in=0 -> hour_out=1, pm_out=1. mode_in=1 -> hour_out=13, pm_out=0.
- With CLOCK_HMS_ALARM_EN: alarm 07:30, alarm_en_in=1, clock reaching 07:30:00 -> alarm_out=1. Drop alarm_en_in -> alarm_out=0 one cycle later.
